// File: rtl/mc_fetch_regs.sv
// Multicycle fetch/holding registers: pc, old_pc, instr, operand latches, decode fields, instret, misalign flag.
// Loads land on the enabling edge (zero extra latency); no backpressure, enables are taken every cycle.
module mc_fetch_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCwrite,
  input  logic        OldPCwrite,
  input  logic        IRwrite,
  input  logic        AdrSel,
  input  logic        MemWrite,
  input  logic [31:0] result,
  input  logic [31:0] alu_result,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [31:0] pc,
  output logic [31:0] old_pc,
  output logic [31:0] instr,
  output logic [31:0] mdr,
  output logic [31:0] a_reg,
  output logic [31:0] b_reg,
  output logic [31:0] alu_out,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] instret,
  output logic        misalign_err
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic [31:0] r_pc;
  logic [31:0] r_old_pc;
  logic [31:0] r_instr;
  logic [31:0] r_mdr;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_alu_out;
  logic [31:0] r_instret;
  logic        r_misalign;

  logic [31:0] w_pc_nxt;
  logic [31:0] w_old_pc_nxt;
  logic [31:0] w_instr_nxt;
  logic [31:0] w_instret_nxt;
  logic        w_misalign_nxt;

  // Every next-state term reads only pre-edge state, so simultaneous enables stay independent.
  always_comb begin
    w_pc_nxt       = r_pc;
    w_old_pc_nxt   = r_old_pc;
    w_instr_nxt    = r_instr;
    w_instret_nxt  = r_instret;
    w_misalign_nxt = r_misalign;
    if (PCwrite) begin
      w_pc_nxt       = {result[31:2], 2'b00};
      w_misalign_nxt = r_misalign | (result[1:0] != 2'b00);
    end
    if (OldPCwrite) begin
      w_old_pc_nxt = r_pc;
    end
    if (IRwrite) begin
      w_instr_nxt   = mem_rdata;
      w_instret_nxt = r_instret + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_old_pc   <= RESET_PC;
      r_instr    <= NOP_INSTR;
      r_mdr      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_alu_out  <= '0;
      r_instret  <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_old_pc   <= w_old_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_mdr      <= mem_rdata;
      r_a        <= rd1;
      r_b        <= rd2;
      r_alu_out  <= alu_result;
      r_instret  <= w_instret_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  assign mem_addr     = AdrSel ? result : r_pc;
  assign mem_wdata    = r_b;
  assign mem_we       = MemWrite;

  assign pc           = r_pc;
  assign old_pc       = r_old_pc;
  assign instr        = r_instr;
  assign mdr          = r_mdr;
  assign a_reg        = r_a;
  assign b_reg        = r_b;
  assign alu_out      = r_alu_out;
  assign instret      = r_instret;
  assign misalign_err = r_misalign;

  // Decode fields come from the instruction register only, never from mem_rdata directly.
  assign opcode = r_instr[6:0];
  assign func3  = r_instr[14:12];
  assign func7  = r_instr[31:25];
  assign rs1    = r_instr[19:15];
  assign rs2    = r_instr[24:20];
  assign rd     = r_instr[11:7];

endmodule

// File: doc/mc_fetch_regs.md
MC_FETCH_REGS -- requirements
Module: mc_fetch_regs

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- PCwrite  input  1  load pc from result
- OldPCwrite  input  1  load old_pc from pc
- IRwrite  input  1  load instr from mem_rdata
- AdrSel  input  1  memory address select: 0 = pc, 1 = result
- MemWrite  input  1  memory write request
- result  input  32  datapath ResultSrc-mux output
- alu_result  input  32  combinational ALU output
- rd1  input  32  register-file read data 1
- rd2  input  32  register-file read data 2
- mem_rdata  input  32  memory read data, combinational read
- mem_addr  output  32  memory address
- mem_wdata  output  32  memory write data
- mem_we  output  1  memory write enable
- pc, old_pc, instr, mdr, a_reg, b_reg, alu_out  output  32 each  architectural/holding registers
- opcode  output  7  instr[6:0]
- func3  output  3  instr[14:12]
- func7  output  7  instr[31:25]
- rs1, rs2, rd  output  5 each  instr[19:15], instr[24:20], instr[11:7]
- instret  output  32  retired-fetch counter
- misalign_err  output  1  sticky misaligned-PC flag

Function
REQ-003 SHALL drive mem_addr = AdrSel ? result : pc, combinationally.
REQ-004 SHALL drive mem_wdata = b_reg and mem_we = MemWrite, combinationally.
REQ-005 SHALL load pc with {result[31:2],2'b00} on a clock edge with PCwrite=1; otherwise hold.
REQ-006 SHALL set misalign_err on a PCwrite edge where result[1:0]!=2'b00; it stays set until reset.
REQ-007 SHALL load old_pc with the pre-edge pc when OldPCwrite=1, also when PCwrite=1 in the same cycle; otherwise hold.
REQ-008 SHALL load instr with mem_rdata when IRwrite=1; otherwise hold.
REQ-009 SHALL load mdr from mem_rdata, a_reg from rd1, b_reg from rd2, and alu_out from alu_result on every edge, unconditionally.
REQ-010 SHALL derive opcode, func3, func7, rs1, rs2 and rd combinationally from instr only; they change only after an IRwrite edge.
REQ-011 SHALL increment instret by 1 on each IRwrite edge, wrapping from 32'hFFFF_FFFF to 0.
REQ-012 SHALL apply all simultaneous enables (PCwrite, OldPCwrite, IRwrite) independently in the same edge. Each SHALL use pre-edge values of pc and mem_addr.
REQ-013 SHALL ignore MemWrite for internal state; no register depends on it.
REQ-014 SHALL have zero-cycle latency from enable to value: the loaded value is visible at outputs immediately after the enabling edge.

Reset
REQ-015 SHALL, while rst=1, force the following values regardless of clk: pc=RESET_PC, old_pc=RESET_PC, instr=32'h0000_0013 (NOP), mdr=a_reg=b_reg=alu_out=0, instret=0, misalign_err=0.
REQ-016 SHALL ignore all enables while rst=1. The first update SHALL occur on the first rising edge after rst deasserts.
REQ-017 SHALL, on rst asserted mid-operation, return all registers to reset values asynchronously. No partial load SHALL survive.

Verification
REQ-018 Fetch: pc=0, mem_rdata=32'h0020_8133, result=4, PCwrite=OldPCwrite=IRwrite=1, one edge -> pc=4, old_pc=0, instr=32'h0020_8133, opcode=7'h33, rd=2, rs1=1, rs2=2, instret=1.
REQ-019 Store address: AdrSel=1, result=32'h100, MemWrite=1, rd2=32'hDEAD_BEEF one cycle earlier -> mem_addr=32'h100, mem_wdata=32'hDEAD_BEEF, mem_we=1; pc unchanged.
REQ-020 Misalign: PCwrite=1, result=32'h0000_0006 -> pc=32'h0000_0004, misalign_err=1. A later aligned PCwrite SHALL leave misalign_err=1.
REQ-021 Wrap: preload instret to 32'hFFFF_FFFF via repeated fetches, or force it, then one IRwrite edge -> instret=0.
REQ-022 Async reset: assert rst between edges after several fetches -> all outputs reach reset values before the next edge. Release rst, then one fetch -> instret=1, pc=result.
REQ-023 Hold: all enables 0 for 3 edges with changing mem_rdata and result -> pc, old_pc, instr and instret unchanged. mdr and alu_out track their inputs with 1-cycle delay.
